// File: rtl/imem_loader.sv
// imem_loader: loads a program into instruction memory from a byte stream.
//   Bytes are assembled big-endian into DATA_WIDTH-bit words and written to
//   consecutive word addresses from 0. The CPU is held (halt + reset) while
//   loading and released to run from address 0 after HALT_WORD is written.
// Ports:
//   i_clock, i_reset (async, active-low)
//   i_start                       : begin a load (IDLE, RUN, ERROR only)
//   i_byte, i_byte_valid          : byte stream in; o_byte_ready accepts it
//   o_mem_we/o_mem_addr/o_mem_data: instruction-memory write port
//   o_haltsignal, o_cpu_reset     : hold PC / pipeline while not running
//   o_done                        : one-cycle pulse on entering RUN
//   o_overflow                    : sticky, memory filled without HALT_WORD
//   o_word_count                  : words written in the current load
module imem_loader #(
  parameter int unsigned           DATA_WIDTH = 32,
  parameter int unsigned           ADDR_WIDTH = 10,
  parameter logic [DATA_WIDTH-1:0] HALT_WORD  = '1
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_start,
  input  logic [7:0]            i_byte,
  input  logic                  i_byte_valid,
  output logic                  o_byte_ready,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic                  o_haltsignal,
  output logic                  o_cpu_reset,
  output logic                  o_done,
  output logic                  o_overflow,
  output logic [ADDR_WIDTH:0]   o_word_count
);

  localparam int unsigned          NBYTES    = DATA_WIDTH / 8;
  localparam int unsigned          IDX_W     = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam int unsigned          SHIFT_W   = DATA_WIDTH - 8;
  localparam logic [IDX_W-1:0]     LAST_IDX  = IDX_W'(NBYTES - 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_FLUSH,
    S_RUN,
    S_ERROR
  } state_t;

  state_t                  state_q;
  state_t                  state_d;
  logic [IDX_W-1:0]        idx_q;
  logic [SHIFT_W-1:0]      shift_q;
  logic [DATA_WIDTH-1:0]   word_c;
  logic                    accept;
  logic                    word_done;
  logic                    start_load;

  // Only the first NBYTES-1 bytes need storage; the last byte completes the word.
  assign word_c    = {shift_q, i_byte};
  assign accept    = (state_q == S_LOAD) && i_byte_valid;
  assign word_done = accept && (idx_q == LAST_IDX);

  // State register
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d    = state_q;
    start_load = 1'b0;
    unique case (state_q)
      S_IDLE, S_RUN, S_ERROR: begin
        if (i_start) begin
          state_d    = S_LOAD;
          start_load = 1'b1;
        end
      end
      S_LOAD: begin
        if (word_done) state_d = S_WRITE;
      end
      S_WRITE: begin
        // HALT_WORD wins over a full memory: HALT at the last address is a clean finish.
        if (o_mem_data == HALT_WORD)      state_d = S_FLUSH;
        else if (o_mem_addr == LAST_ADDR) state_d = S_ERROR;
        else                              state_d = S_LOAD;
      end
      S_FLUSH: state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Registered outputs and datapath; status outputs follow the state being entered.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      idx_q        <= '0;
      shift_q      <= '0;
      o_byte_ready <= 1'b0;
      o_mem_we     <= 1'b0;
      o_mem_addr   <= '0;
      o_mem_data   <= '0;
      o_haltsignal <= 1'b1;
      o_cpu_reset  <= 1'b1;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
      o_word_count <= '0;
    end else begin
      o_byte_ready <= (state_d == S_LOAD);
      o_mem_we     <= (state_d == S_WRITE);
      o_haltsignal <= (state_d != S_RUN);
      o_cpu_reset  <= (state_d != S_RUN);
      o_done       <= (state_q == S_FLUSH);

      if (start_load) begin
        idx_q        <= '0;
        o_word_count <= '0;
        o_overflow   <= 1'b0;
      end

      if (accept) begin
        shift_q <= word_c[SHIFT_W-1:0];
        idx_q   <= idx_q + IDX_W'(1);
      end

      if (word_done) begin
        o_mem_addr <= o_word_count[ADDR_WIDTH-1:0];
        o_mem_data <= word_c;
      end

      if (state_q == S_WRITE) begin
        o_word_count <= o_word_count + (ADDR_WIDTH+1)'(1);
        if (state_d == S_ERROR) o_overflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Testbench for imem_loader: random byte streams with gaps, checked against a
// word-level model of the expected memory writes and completion status.
module tb_imem_loader;

  localparam int unsigned AW    = 2;
  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

  logic          i_clock = 1'b0;
  logic          i_reset = 1'b0;
  logic          i_start = 1'b0;
  logic [7:0]    i_byte = 8'h00;
  logic          i_byte_valid = 1'b0;
  logic          o_byte_ready;
  logic          o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_data;
  logic          o_haltsignal;
  logic          o_cpu_reset;
  logic          o_done;
  logic          o_overflow;
  logic [AW:0]   o_word_count;

  imem_loader #(.DATA_WIDTH(32), .ADDR_WIDTH(AW), .HALT_WORD(HALT)) u_dut (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_start     (i_start),
    .i_byte      (i_byte),
    .i_byte_valid(i_byte_valid),
    .o_byte_ready(o_byte_ready),
    .o_mem_we    (o_mem_we),
    .o_mem_addr  (o_mem_addr),
    .o_mem_data  (o_mem_data),
    .o_haltsignal(o_haltsignal),
    .o_cpu_reset (o_cpu_reset),
    .o_done      (o_done),
    .o_overflow  (o_overflow),
    .o_word_count(o_word_count)
  );

  always #5 i_clock = ~i_clock;

  typedef struct {
    int          addr;
    logic [31:0] data;
    bit          last;
  } wr_t;

  wr_t exp_q[$];
  int  tests = 0;
  int  fails = 0;
  int  done_cnt = 0;
  bit  chk_ready_next = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Write monitor: every o_mem_we must match the next expected write.
  initial begin
    wr_t w;
    forever begin
      @(negedge i_clock);
      if (!i_reset) begin
        chk_ready_next = 1'b0;
      end else begin
        if (chk_ready_next) check("ready_after_write", o_byte_ready, 1);
        chk_ready_next = 1'b0;
        if (o_done) done_cnt++;
        if (o_mem_we) begin
          if (exp_q.size() == 0) begin
            check("spurious_we", o_mem_we, 0);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", o_mem_addr, w.addr);
            check("wr_data", o_mem_data, w.data);
            check("ready_in_write", o_byte_ready, 0);
            chk_ready_next = !w.last;
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic do_start();
    i_start = 1'b1;
    @(negedge i_clock);
    i_start = 1'b0;
    check("start_ready", o_byte_ready, 1);
    check("start_halt", o_haltsignal, 1);
    check("start_cpu_reset", o_cpu_reset, 1);
    check("start_count", o_word_count, 0);
    check("start_overflow", o_overflow, 0);
  endtask

  // Present bytes with random gaps; a presented byte is held until accepted,
  // and a byte is always presented while the loader is not ready.
  task automatic send_stream(input logic [7:0] bs[$], input int gap_pct);
    int i = 0;
    int guard = 0;
    bit xfer;
    while (i < bs.size() && guard < 4000) begin
      if (!i_byte_valid) begin
        if (!o_byte_ready || ($urandom_range(0, 99) >= gap_pct)) begin
          i_byte       = bs[i];
          i_byte_valid = 1'b1;
        end else begin
          i_byte = 8'($urandom);
        end
      end
      xfer = i_byte_valid && o_byte_ready;
      @(negedge i_clock);
      guard++;
      if (xfer) begin
        i++;
        i_byte_valid = 1'b0;
      end
    end
    i_byte_valid = 1'b0;
    check("stream_sent", i, bs.size());
  endtask

  // Model: words go to addresses 0.. until HALT (done) or the last address (overflow).
  task automatic run_load(input logic [31:0] words[$], input int gap_pct);
    wr_t e;
    logic [7:0] bs[$];
    logic [31:0] w;
    int n = 0;
    int k = 0;
    bit halt_seen = 1'b0;
    bit ovf = 1'b0;
    exp_q.delete();
    for (int i = 0; i < words.size(); i++) begin
      if (halt_seen || ovf) break;
      w      = words[i];
      e.addr = i;
      e.data = w;
      e.last = 1'b0;
      if (w == HALT) begin
        halt_seen = 1'b1;
        e.last    = 1'b1;
      end else if (i == DEPTH - 1) begin
        ovf    = 1'b1;
        e.last = 1'b1;
      end
      exp_q.push_back(e);
      bs.push_back(w[31:24]);
      bs.push_back(w[23:16]);
      bs.push_back(w[15:8]);
      bs.push_back(w[7:0]);
      n++;
    end
    done_cnt = 0;
    do_start();
    send_stream(bs, gap_pct);
    while (k < 10 && !(o_done || o_overflow)) begin
      @(negedge i_clock);
      k++;
    end
    if (halt_seen) check("done_latency", k, 2);
    else           check("ovf_latency", k, 1);
    check("word_count", o_word_count, n);
    check("overflow", o_overflow, ovf);
    check("haltsignal", o_haltsignal, !halt_seen);
    check("cpu_reset", o_cpu_reset, !halt_seen);
    @(negedge i_clock);
    check("done_width", o_done, 0);
    check("writes_left", exp_q.size(), 0);
    if (!halt_seen) begin
      repeat (3) @(negedge i_clock);
      check("ovf_hold_halt", o_haltsignal, 1);
      check("ovf_sticky", o_overflow, 1);
    end
    check("done_count", done_cnt, halt_seen ? 1 : 0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0)      w = 32'hFFFF_FF00;
    else if (sel == 1) w = 32'h0;
    else               w = $urandom;
    if (w == HALT) w = 32'h7FFF_FFFF;
    return w;
  endfunction

  initial begin
    logic [31:0] words[$];
    logic [7:0]  bs[$];
    wr_t e;
    int nw;

    // Reset values while held in reset.
    #12;
    check("rst_ready", o_byte_ready, 0);
    check("rst_we", o_mem_we, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_data", o_mem_data, 0);
    check("rst_halt", o_haltsignal, 1);
    check("rst_cpu_reset", o_cpu_reset, 1);
    check("rst_done", o_done, 0);
    check("rst_overflow", o_overflow, 0);
    check("rst_count", o_word_count, 0);

    @(negedge i_clock);
    i_reset = 1'b1;
    repeat (3) @(negedge i_clock);
    check("idle_halt", o_haltsignal, 1);
    check("idle_cpu_reset", o_cpu_reset, 1);
    check("idle_ready", o_byte_ready, 0);

    // Directed normal load, back-to-back bytes.
    words = '{32'h2001_0005, 32'h0000_0000, HALT};
    run_load(words, 0);
    // Same image again from RUN, with gaps.
    run_load(words, 50);

    // Reset after two bytes of the second word.
    exp_q.delete();
    e.addr = 0;
    e.data = 32'hA1B2_C3D4;
    e.last = 1'b0;
    exp_q.push_back(e);
    bs = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22};
    do_start();
    send_stream(bs, 30);
    i_reset = 1'b0;
    #1;
    check("midrst_count", o_word_count, 0);
    check("midrst_we", o_mem_we, 0);
    check("midrst_ready", o_byte_ready, 0);
    check("midrst_halt", o_haltsignal, 1);
    check("midrst_cpu_reset", o_cpu_reset, 1);
    check("midrst_writes", exp_q.size(), 0);
    repeat (2) @(negedge i_clock);
    i_reset = 1'b1;
    repeat (3) @(negedge i_clock);
    check("midrst_idle_ready", o_byte_ready, 0);
    words = '{32'h1234_5678, HALT};
    run_load(words, 20);

    // HALT at the last address completes normally.
    words = '{rand_word(), rand_word(), rand_word(), HALT};
    run_load(words, 25);

    // Fill memory without HALT, then a new load clears overflow.
    words = '{32'h0000_0001, 32'h0000_0002, 32'hFFFF_FF00, 32'h0000_0004};
    run_load(words, 10);
    words = '{32'hDEAD_BEEF, HALT};
    run_load(words, 40);

    // Randomized loads.
    for (int t = 0; t < 14; t++) begin
      words.delete();
      if ($urandom_range(0, 3) == 0) begin
        for (int i = 0; i < DEPTH; i++) words.push_back(rand_word());
      end else begin
        nw = $urandom_range(0, DEPTH - 1);
        for (int i = 0; i < nw; i++) words.push_back(rand_word());
        words.push_back(HALT);
      end
      run_load(words, $urandom_range(0, 70));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
